// File: rtl/prca_pkg.sv
// Shared types, defaults and helpers for the pipelined ripple-carry adder.
// Provides the add/sub opcode, default geometry, stage count and full-adder cell.
package prca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Returns 0 for an illegal geometry so the top can refuse to elaborate.
    function automatic int prca_stages(int width, int chunk);
        if (chunk <= 0 || width <= 0 || (width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

    // One bit-level full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(logic x, logic y, logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_chunk.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells.
// Ports: a, b, c_in -> sum, c_out, c_msb_in (carry into the slice MSB).
module rca_chunk
    import prca_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic cy;
    logic msb;

    // The carry ripples through a block-local variable so the chain
    // stays a single sequential evaluation rather than a bit-vector loop.
    always_comb begin
        cy  = c_in;
        msb = c_in;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            msb = cy;
            {cy, sum[i]} = full_add(a[i], b[i], cy);
        end
    end

    assign c_out    = cy;
    assign c_msb_in = msb;

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b, c_in, sub,
// out_valid/out_ready, sum, c_out, overflow.
// Build option: define PRCA_OVERFLOW_EN to track the MSB carry and report
// signed overflow; otherwise overflow is tied to 0.
module pipelined_rca_adder
    import prca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int STAGES = prca_stages(WIDTH, CHUNK);

    if (STAGES == 0) begin : g_cfg_check
        $error("pipelined_rca_adder: WIDTH must be a multiple of CHUNK");
    end

    // Stage state. acc_q holds finished sum slices in its low bits and the
    // still-unconsumed A slices above them; b_q carries the effective B.
    logic             vld_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] acc_q [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];

    // Per-stage inputs and next values.
    logic             vld_src [STAGES];
    logic             c_src   [STAGES];
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic [CHUNK-1:0] s_sl    [STAGES];
    logic             cy_d    [STAGES];
    logic             c_msb   [STAGES];
    logic [WIDTH-1:0] acc_d   [STAGES];

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;

    assign op = sub ? OP_SUB : OP_ADD;

    // Subtract is a + ~b + ~c_in, so the borrow-in is inverted too.
    always_comb begin
        b_eff = b;
        c_eff = c_in;
        unique case (op)
            OP_ADD: begin
                b_eff = b;
                c_eff = c_in;
            end
            OP_SUB: begin
                b_eff = ~b;
                c_eff = ~c_in;
            end
        endcase
    end

    assign stall    = vld_q[STAGES-1] && !out_ready;
    assign in_ready = !stall && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK =
            WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

        if (k == 0) begin : g_head
            assign vld_src[k] = in_valid;
            assign a_src[k]   = a;
            assign b_src[k]   = b_eff;
            assign c_src[k]   = c_eff;
        end else begin : g_body
            assign vld_src[k] = vld_q[k-1];
            assign a_src[k]   = acc_q[k-1];
            assign b_src[k]   = b_q[k-1];
            assign c_src[k]   = cy_q[k-1];
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a        (a_src[k][k*CHUNK +: CHUNK]),
            .b        (b_src[k][k*CHUNK +: CHUNK]),
            .c_in     (c_src[k]),
            .sum      (s_sl[k]),
            .c_out    (cy_d[k]),
            .c_msb_in (c_msb[k])
        );

        // Replace this stage's A slice with its finished sum slice.
        assign acc_d[k] = (a_src[k] & ~MASK)
                        | (WIDTH'(s_sl[k]) << (k * CHUNK));
    end

    // The whole pipe moves together; empty slots advance like full ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_src[k];
                cy_q[k]  <= cy_d[k];
                acc_q[k] <= acc_d[k];
                b_q[k]   <= b_src[k];
            end
        end
    end

    // The last stage's copy of B is never consumed.
    logic unused_tail;
    assign unused_tail = ^b_q[STAGES-1];

    assign out_valid = vld_q[STAGES-1];
    assign sum       = acc_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];

`ifdef PRCA_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= cy_d[STAGES-1] ^ c_msb[STAGES-1];
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_msb;
    assign unused_msb = c_msb[STAGES-1];
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder.
// Covers 32/8, 12/4 and 8/8 geometries; honours PRCA_OVERFLOW_EN.
module tb_pipelined_rca_adder;

`ifdef PRCA_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, c_in, sub;
    logic        out_valid, out_ready, c_out, overflow;
    logic [31:0] a, b, sum;

    logic        w12_in_valid, w12_in_ready, w12_c_in, w12_sub;
    logic        w12_out_valid, w12_out_ready, w12_c_out, w12_overflow;
    logic [11:0] w12_a, w12_b, w12_sum;

    logic        w8_in_valid, w8_in_ready, w8_c_in, w8_sub;
    logic        w8_out_valid, w8_out_ready, w8_c_out, w8_overflow;
    logic [7:0]  w8_a, w8_b, w8_sum;

    int checks = 0;
    int errors = 0;

    pipelined_rca_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    pipelined_rca_adder #(.WIDTH(12), .CHUNK(4)) u_w12 (
        .clk(clk), .rst(rst),
        .in_valid(w12_in_valid), .in_ready(w12_in_ready),
        .a(w12_a), .b(w12_b), .c_in(w12_c_in), .sub(w12_sub),
        .out_valid(w12_out_valid), .out_ready(w12_out_ready),
        .sum(w12_sum), .c_out(w12_c_out), .overflow(w12_overflow)
    );

    pipelined_rca_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst(rst),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .a(w8_a), .b(w8_b), .c_in(w8_c_in), .sub(w8_sub),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .sum(w8_sum), .c_out(w8_c_out), .overflow(w8_overflow)
    );

    // Hand-computed stream: {a, b, c_in, sub} -> {sum, c_out, ovf}.
    logic [31:0] t_a  [8] = '{32'h00000010, 32'h80000000, 32'h00000010,
                              32'h12345678, 32'h00000000, 32'h0000FFFF,
                              32'h80000000, 32'hFFFFFFFF};
    logic [31:0] t_b  [8] = '{32'h00000020, 32'h80000000, 32'h00000001,
                              32'h11111111, 32'h00000001, 32'h00000001,
                              32'h00000001, 32'hFFFFFFFF};
    logic        t_ci [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic        t_sb [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] t_s  [8] = '{32'h00000030, 32'h00000000, 32'h0000000F,
                              32'h2345678A, 32'hFFFFFFFF, 32'h00010000,
                              32'h7FFFFFFF, 32'hFFFFFFFF};
    logic        t_co [8] = '{0, 1, 1, 0, 0, 0, 1, 1};
    logic        t_ov [8] = '{0, 1, 0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_in;
        int n_out;
        logic hs_in;
        logic seen;

        rst = 1'b1;
        in_valid = 0; a = '0; b = '0; c_in = 0; sub = 0; out_ready = 1;
        w12_in_valid = 0; w12_a = '0; w12_b = '0; w12_c_in = 0;
        w12_sub = 0; w12_out_ready = 1;
        w8_in_valid = 0; w8_a = '0; w8_b = '0; w8_c_in = 0;
        w8_sub = 0; w8_out_ready = 1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_w12_valid", w12_out_valid, 0);
        check("rst_w8_valid", w8_out_valid, 0);

        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Full carry ripple, latency 4
        a = 32'hFFFFFFFF; b = 32'h00000001; c_in = 0; sub = 0; in_valid = 1;
        tick();
        in_valid = 0;
        check("ripple_lat1", out_valid, 0);
        tick();
        check("ripple_lat2", out_valid, 0);
        tick();
        check("ripple_lat3", out_valid, 0);
        tick();
        check("ripple_valid", out_valid, 1);
        check("ripple_sum", sum, 32'h00000000);
        check("ripple_c_out", c_out, 1);
        check("ripple_ovf", overflow, 0);
        tick();
        check("ripple_drain", out_valid, 0);

        // Subtract with borrow, two beats back to back
        a = 32'd5; b = 32'd7; c_in = 0; sub = 1; in_valid = 1;
        tick();
        c_in = 1;
        tick();
        in_valid = 0; sub = 0; c_in = 0;
        tick();
        tick();
        check("sub0_valid", out_valid, 1);
        check("sub0_sum", sum, 32'hFFFFFFFE);
        check("sub0_c_out", c_out, 0);
        tick();
        check("sub1_valid", out_valid, 1);
        check("sub1_sum", sum, 32'hFFFFFFFD);
        check("sub1_c_out", c_out, 0);
        tick();

        // Signed overflow
        a = 32'h7FFFFFFF; b = 32'h00000001; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        tick();
        check("ovf_valid", out_valid, 1);
        check("ovf_sum", sum, 32'h80000000);
        check("ovf_c_out", c_out, 0);
        check("ovf_flag", overflow, OVF_EN);
        tick();

        // Backpressure stream of 8 beats, out_ready low for cycles 6..8
        n_in = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            in_valid  = (n_in < 8);
            if (n_in < 8) begin
                a = t_a[n_in]; b = t_b[n_in];
                c_in = t_ci[n_in]; sub = t_sb[n_in];
            end
            #1;
            if (cyc >= 6 && cyc < 9) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_valid", out_valid, 1);
                check("stall_sum_held", sum, t_s[n_out]);
            end
            if (cyc == 9) begin
                check("resume_in_ready", in_ready, 1);
            end
            if (out_valid && out_ready) begin
                check("stream_sum", sum, t_s[n_out]);
                check("stream_c_out", c_out, t_co[n_out]);
                check("stream_ovf", overflow, t_ov[n_out] & OVF_EN);
                n_out++;
            end
            hs_in = in_valid && in_ready;
            tick();
            if (hs_in) n_in++;
        end
        in_valid = 0; out_ready = 1;
        check("stream_count", n_out, 8);
        #1;
        check("stream_no_extra", out_valid, 0);

        // Reset mid-flight: three beats in, then one cycle of reset
        for (int i = 1; i <= 3; i++) begin
            a = i; b = i; c_in = 0; sub = 0; in_valid = 1;
            tick();
        end
        in_valid = 0;
        rst = 1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_c_out", c_out, 0);
        check("midrst_ovf", overflow, 0);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("midrst_no_stale", seen, 0);

        a = 32'd7; b = 32'd8; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        check("after_rst_lat3", out_valid, 0);
        tick();
        check("after_rst_valid", out_valid, 1);
        check("after_rst_sum", sum, 32'h0000000F);
        tick();

        // 12/4 geometry, latency 3
        w12_a = 12'hFFF; w12_b = 12'h001; w12_in_valid = 1;
        tick();
        w12_in_valid = 0;
        check("w12_lat1", w12_out_valid, 0);
        tick();
        check("w12_lat2", w12_out_valid, 0);
        tick();
        check("w12_valid", w12_out_valid, 1);
        check("w12_sum", w12_sum, 12'h000);
        check("w12_c_out", w12_c_out, 1);
        check("w12_ovf", w12_overflow, 0);

        // 8/8 geometry, latency 1
        w8_a = 8'hFF; w8_b = 8'h01; w8_in_valid = 1;
        #1;
        check("w8_pre_valid", w8_out_valid, 0);
        tick();
        w8_in_valid = 0;
        check("w8_valid", w8_out_valid, 1);
        check("w8_sum", w8_sum, 8'h00);
        check("w8_c_out", w8_c_out, 1);
        tick();
        check("w8_drain", w8_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
